load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the ALU/control stage and DataMemory. Accepts load/store requests
//    (byte, half, word; signed/unsigned loads) and drives DataMemory's word-only port.
//  Sub-word stores are read-modify-write sequences on the word port.
//  Returns aligned, extended load data to the writeback mux.
//  Flags misaligned accesses; misaligned requests never touch memory.
// PARAMETERS
//  ADDR_W      32  width of endereco / mem_endereco
//  ERR_ON_MIS   1  1: misaligned access -> resp_erro=1, no memory access; 0: low address bits forced to 0
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  rst_n          in   1       synchronous, active-low reset
//  req_valid      in   1       request present
//  req_ready      out  1       1 only in IDLE; request accepted at edge when valid&ready
//  req_store      in   1       1=store, 0=load
//  req_op         in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  endereco       in   ADDR_W  byte address (ALUresult)
//  writedata      in   32      store data (low byte/half used for B/H)
//  resp_valid     out  1       one-cycle pulse: request complete
//  resp_loaddata  out  32      extended load data, valid with resp_valid (0 for stores)
//  resp_erro      out  1       misaligned/illegal op, valid with resp_valid
//  mem_memwrite   out  1       to DataMemory memwrite
//  mem_endereco   out  ADDR_W  to DataMemory endereco, always word aligned ([1:0]=00)
//  mem_writedata  out  32      to DataMemory writedata
//  mem_readdata   in   32      from DataMemory readdata (combinational read of mem_endereco)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; resp_valid=0, resp_erro=0, resp_loaddata=0,
//    internal latches cleared.
//  mem_memwrite is gated combinationally by rst_n: no write in any cycle with rst_n=0.
//  Reset mid-RMW: the pending write is dropped.
//  Request latched on accept (addr, op, store, data). req_valid while busy is ignored, not queued.
//  Little-endian: byte k of a word = bits [8k+7:8k], k = addr[1:0].
//  Alignment: H needs addr[0]=0, W needs addr[1:0]=00.
//  Illegal ops are errors: store with op BU/HU, and encodings 011/11x.
//  FSM:
//   IDLE   -> ERR (error), LOAD (load), ST_W (SW), RMW_RD (SB/SH)
//   LOAD   read mem_readdata, extract lane, sign/zero extend into resp_loaddata reg -> RESP
//   ST_W   mem_memwrite=1, mem_writedata=latched data -> RESP
//   RMW_RD capture mem_readdata into merge buffer -> RMW_WR
//   RMW_WR mem_memwrite=1, mem_writedata=buffer with target lane replaced -> RESP
//   ERR    resp_valid=1, resp_erro=1, mem_memwrite=0 -> IDLE
//   RESP   resp_valid=1, resp_erro=0 -> IDLE
//  Latency (accept edge -> resp_valid cycle):
//    error 1 cycle; load 2; SW 2; SB/SH 3.
//    Next accept is possible the cycle after resp_valid.
//  mem_memwrite is 0 in every state except ST_W and RMW_WR, and is high exactly one cycle per store.
//  resp_loaddata is held until the next response and is cleared for store and error responses.
//  mem_endereco = {latched_addr[ADDR_W-1:2],2'b00}; it is 0 in IDLE.
//  ERR_ON_MIS=0: misaligned accesses proceed, with H forcing addr[0]=0 and W forcing [1:0]=00.
// STRUCTURE
//  lsu_pkg:
//    op encodings (OP_B, OP_H, OP_W, OP_BU, OP_HU)
//    state encoding (IDLE, LOAD, ST_W, RMW_RD, RMW_WR, ERR, RESP)
//    function is_misaligned(op, addr[1:0])
//  Sub-module lsu_lane_align: combinational lane extract + sign/zero extend (loads)
//    and lane merge (stores). FSM and registers stay in load_store_unit.
// TESTING (bench instantiates load_store_unit + DataMemory; clk period 10)
//  SW addr 0x04 data 0xDEADBEEF, then LW 0x04:
//    -> store resp 2 cycles after accept; load resp_loaddata=0xDEADBEEF.
//  After the above, SB addr 0x05 data 0x000000AA:
//    -> one read cycle then one write cycle; LW 0x04 = 0xDEADAAEF.
//  LB 0x07 -> 0xFFFFFFDE; LBU 0x07 -> 0x000000DE; LH 0x06 -> 0xFFFFDEAD; LHU 0x06 -> 0x0000DEAD.
//  LW 0x06 and SH 0x09:
//    -> resp_erro=1 one cycle after accept; mem_memwrite never asserted; mem contents unchanged.
//  Assert rst_n=0 during the RMW_RD cycle of SH 0x08 (data 0x1234), with 0xCAFEBABE preset at 0x08:
//    -> no write; word 0x08 still 0xCAFEBABE; outputs 0, req_ready=1 after release.
//  req_valid held high through a load:
//    -> req_ready=0 in LOAD/RESP; exactly one response per accept; mem_memwrite stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and request decode helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ST_W,
      RMW_RD,
      RMW_WR,
      ERR,
      RESP
   } state_e;

   typedef struct packed {
      logic        store;
      logic [2:0]  op;
      logic [31:0] data;
   } lsu_req_t;

   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
      case (op)
         OP_H, OP_HU: return addr_lo[0];
         OP_W:        return addr_lo != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

   // BU/HU only make sense as loads; 011 and 11x are unassigned.
   function automatic logic is_illegal(input logic [2:0] op, input logic store);
      case (op)
         OP_B, OP_H, OP_W: return 1'b0;
         OP_BU, OP_HU:     return store;
         default:          return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane handling: load extract + sign/zero extend, store lane merge.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v    = rdata[{lane, 3'b000} +: 8];
      half_v    = lane[1] ? rdata[31:16] : rdata[15:0];
      load_data = rdata;
      case (op)
         OP_B:    load_data = {{24{byte_v[7]}}, byte_v};
         OP_BU:   load_data = {24'h0, byte_v};
         OP_H:    load_data = {{16{half_v[15]}}, half_v};
         OP_HU:   load_data = {16'h0, half_v};
         default: load_data = rdata;
      endcase

      merged = rdata;
      case (op)
         OP_B: merged[{lane, 3'b000} +: 8] = wdata[7:0];
         OP_H: begin
            if (lane[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
         end
         OP_W:    merged = wdata;
         default: merged = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-only data memory; sub-word stores are RMW.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter bit ERR_ON_MIS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] endereco,
   input  logic [31:0]       writedata,
   output logic              resp_valid,
   output logic [31:0]       resp_loaddata,
   output logic              resp_erro,
   output logic              mem_memwrite,
   output logic [ADDR_W-1:0] mem_endereco,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   lsu_req_t          req_q, req_d;
   logic [31:0]       buf_q, buf_d;
   logic [31:0]       ld_q, ld_d;

   logic [ADDR_W-1:0] acc_addr;
   logic              acc_err;
   logic              wr_en;
   logic [31:0]       align_rdata;
   logic [31:0]       align_load;
   logic [31:0]       align_merged;

   lsu_lane_align u_align (
      .op        (req_q.op),
      .lane      (addr_q[1:0]),
      .rdata     (align_rdata),
      .wdata     (req_q.data),
      .load_data (align_load),
      .merged    (align_merged)
   );

   always_comb begin
      // With errors disabled, misaligned accesses are silently rounded down.
      acc_addr = endereco;
      if (!ERR_ON_MIS) begin
         case (req_op)
            OP_H, OP_HU: acc_addr[0]   = 1'b0;
            OP_W:        acc_addr[1:0] = 2'b00;
            default:     acc_addr      = endereco;
         endcase
      end
      acc_err = is_illegal(req_op, req_store) |
                (ERR_ON_MIS & is_misaligned(req_op, endereco[1:0]));
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      req_d         = req_q;
      buf_d         = buf_q;
      ld_d          = ld_q;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_erro     = 1'b0;
      wr_en         = 1'b0;
      mem_writedata = '0;
      mem_endereco  = {addr_q[ADDR_W-1:2], 2'b00};
      align_rdata   = mem_readdata;
      case (state_q)
         IDLE: begin
            req_ready    = 1'b1;
            mem_endereco = '0;
            if (req_valid) begin
               addr_d = acc_addr;
               req_d  = '{store: req_store, op: req_op, data: writedata};
               if (acc_err) begin
                  ld_d    = '0;
                  state_d = ERR;
               end else if (!req_store)  state_d = LOAD;
               else if (req_op == OP_W)  state_d = ST_W;
               else                      state_d = RMW_RD;
            end
         end
         LOAD: begin
            ld_d    = align_load;
            state_d = RESP;
         end
         ST_W: begin
            wr_en         = 1'b1;
            mem_writedata = req_q.data;
            ld_d          = '0;
            state_d       = RESP;
         end
         RMW_RD: begin
            buf_d   = mem_readdata;
            state_d = RMW_WR;
         end
         RMW_WR: begin
            align_rdata   = buf_q;
            wr_en         = 1'b1;
            mem_writedata = align_merged;
            ld_d          = '0;
            state_d       = RESP;
         end
         ERR: begin
            resp_valid = 1'b1;
            resp_erro  = 1'b1;
            state_d    = IDLE;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Gating by rst_n keeps a write from escaping in the reset cycle itself.
   assign mem_memwrite  = wr_en & rst_n;
   assign resp_loaddata = ld_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         req_q   <= '0;
         buf_q   <= '0;
         ld_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         buf_q   <= buf_d;
         ld_q    <= ld_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: driver pushes model responses, monitor pops on resp_valid.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_op = 3'b000;
   logic [31:0] endereco = '0;
   logic [31:0] writedata = '0;
   logic        resp_valid;
   logic [31:0] resp_loaddata;
   logic        resp_erro;
   logic        mem_memwrite;
   logic [31:0] mem_endereco;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;

   load_store_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_store     (req_store),
      .req_op        (req_op),
      .endereco      (endereco),
      .writedata     (writedata),
      .resp_valid    (resp_valid),
      .resp_loaddata (resp_loaddata),
      .resp_erro     (resp_erro),
      .mem_memwrite  (mem_memwrite),
      .mem_endereco  (mem_endereco),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata)
   );

   always #5 clk = ~clk;

   // DataMemory: 64 words, combinational read, write on rising edge.
   logic [31:0] mem [0:63];
   logic [31:0] ref_mem [0:63];
   assign mem_readdata = mem[mem_endereco[7:2]];
   always @(posedge clk) if (mem_memwrite) mem[mem_endereco[7:2]] <= mem_writedata;

   typedef struct { logic [31:0] ld; logic err; int cyc; } exp_t;
   exp_t sb[$];

   int nvec = 0, nerr = 0;
   int cyc = 0, n_acc = 0, n_issued = 0, n_wr = 0, exp_wr = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && req_valid && req_ready) n_acc <= n_acc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: everything sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (mem_memwrite) n_wr++;
      if (!rst_n) chk("memwrite_in_reset", {31'b0, mem_memwrite}, 32'd0);
      chk("mem_addr_align", {30'b0, mem_endereco[1:0]}, 32'd0);
      if (req_ready) chk("mem_addr_idle", mem_endereco, 32'd0);
      if (resp_valid) begin
         if (sb.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL spurious_resp: got resp_valid=1 expected no response (t=%0t)", $time);
         end else begin
            e = sb.pop_front();
            chk("resp_loaddata", resp_loaddata, e.ld);
            chk("resp_erro", {31'b0, resp_erro}, {31'b0, e.err});
            chk("resp_latency", cyc, e.cyc);
         end
      end
   end

   // Reference model: byte-addressed little-endian memory semantics.
   task automatic model(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] ld, output logic err,
                        output int lat);
      int size, k, w;
      logic [31:0] word, v, mask;
      w    = int'(a[7:2]);
      k    = int'(a[1:0]);
      word = ref_mem[w];
      size = (op == 3'd0 || op == 3'd4) ? 1 : (op == 3'd1 || op == 3'd5) ? 2 : 4;
      if (st) err = !(op == 3'd0 || op == 3'd1 || op == 3'd2);
      else    err = !(op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5);
      if ((int'(a) % size) != 0) err = 1'b1;
      ld  = '0;
      lat = 1;
      if (err) return;
      if (!st) begin
         v = word >> (8 * k);
         if (size == 1) begin
            v = v & 32'hFF;
            if (op == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
         end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (op == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
         end
         ld  = v;
         lat = 2;
      end else begin
         mask = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * size)) - 1) << (8 * k));
         ref_mem[w] = (word & ~mask) | ((d << (8 * k)) & mask);
         exp_wr++;
         lat = (size == 4) ? 2 : 3;
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 50);
      if (!req_ready) begin
         nvec++; nerr++;
         $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
      end
   endtask

   task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
      exp_t e;
      int lat;
      wait_ready();
      req_valid = 1'b1; req_store = st; req_op = op; endereco = a; writedata = d;
      @(posedge clk);
      #1;
      n_issued++;
      model(st, op, a, d, e.ld, e.err, lat);
      e.cyc = cyc + lat - 1;
      sb.push_back(e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("ready_busy", {31'b0, req_ready}, 32'd0);
         chk("memwrite_load", {31'b0, mem_memwrite}, 32'd0);
      end
      if (hold == 0) @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !req_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         nvec++; nerr++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   initial begin
      int wr_snap;
      for (int i = 0; i < 64; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      repeat (3) @(negedge clk);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_erro", {31'b0, resp_erro}, 32'd0);
      chk("rst_loaddata", resp_loaddata, 32'd0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      rst_n = 1'b1;

      issue(1'b1, 3'b010, 32'h04, 32'hDEADBEEF, 0);
      issue(1'b0, 3'b010, 32'h04, 32'h0, 0);
      issue(1'b1, 3'b000, 32'h05, 32'h000000AA, 0);
      issue(1'b0, 3'b010, 32'h04, 32'h0, 0);
      drain();
      chk("sb_word4", mem[1], 32'hDEADAAEF);
      issue(1'b0, 3'b000, 32'h07, 32'h0, 0);
      issue(1'b0, 3'b100, 32'h07, 32'h0, 0);
      issue(1'b0, 3'b001, 32'h06, 32'h0, 0);
      issue(1'b0, 3'b101, 32'h06, 32'h0, 0);
      drain();
      wr_snap = n_wr;
      issue(1'b0, 3'b010, 32'h06, 32'h0, 0);
      issue(1'b1, 3'b001, 32'h09, 32'h5555, 0);
      drain();
      chk("err_no_write", n_wr, wr_snap);
      chk("err_mem_kept", mem[1], 32'hDEADAAEF);

      // Held req_valid through a load: exactly one accept.
      issue(1'b0, 3'b010, 32'h04, 32'h0, 2);
      drain();

      // Reset during RMW_RD of SH 0x08: the write must never happen.
      mem[2] = 32'hCAFEBABE; ref_mem[2] = 32'hCAFEBABE;
      wait_ready();
      req_valid = 1'b1; req_store = 1'b1; req_op = 3'b001; endereco = 32'h08; writedata = 32'h1234;
      @(posedge clk);
      #1;
      n_issued++;
      rst_n = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rmw_rst_valid", {31'b0, resp_valid}, 32'd0);
      chk("rmw_rst_loaddata", resp_loaddata, 32'd0);
      chk("rmw_rst_mem", mem[2], 32'hCAFEBABE);
      issue(1'b0, 3'b010, 32'h08, 32'h0, 0);
      drain();

      for (int i = 0; i < 250; i++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 0);
      end
      drain();

      chk("accept_count", n_acc, n_issued);
      chk("write_count", n_wr, exp_wr);
      for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
